// File: rtl/cpu_pkg.sv
// Shared types, constants and helpers for the UART transmit scheduler.
package cpu_pkg;

  typedef enum logic {S_IDLE, S_WRITE} tx_sched_state_t;

  localparam int unsigned WORD_BYTES     = 4;
  localparam int unsigned HEX_WORD_BYTES = 8;

  // Lower-case ASCII hex digit for one nibble.
  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return 8'h30 + {4'h0, nib};
    end else begin
      return 8'h57 + {4'h0, nib};
    end
  endfunction

endpackage

// File: rtl/tx_byte_fifo.sv
// Circular byte queue with a level counter; every one of the 2**DEPTH_LOG2 entries is usable.
module tx_byte_fifo #(
  parameter int unsigned DEPTH_LOG2 = 9
) (
  input  logic                  CLK,
  input  logic                  INITIALIZE,
  input  logic                  wr_en,
  input  logic [7:0]            wr_data,
  input  logic                  rd_en,
  output logic [7:0]            rd_data,
  output logic [DEPTH_LOG2:0]   level
);

  logic [7:0]            mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wr_ptr_q;
  logic [DEPTH_LOG2-1:0] rd_ptr_q;
  logic [DEPTH_LOG2:0]   level_q;
  logic                  do_rd;

  assign do_rd = rd_en && (level_q != '0);

  always_ff @(posedge CLK or posedge INITIALIZE) begin
    if (INITIALIZE) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_rd) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (wr_en && !do_rd) begin
        level_q <= level_q + 1'b1;
      end else if (!wr_en && do_rd) begin
        level_q <= level_q - 1'b1;
      end
    end
  end

  // Storage is not reset; stale contents are never visible because the head is gated by level.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data = (level_q != '0) ? mem[rd_ptr_q] : 8'h00;
  assign level   = level_q;

endmodule

// File: rtl/uart_tx_scheduler.sv
// Two-port round-robin print scheduler feeding one UART byte queue.
// Build option: define HEX_PRINT_EN to emit word requests as 8 ASCII hex digits.
module uart_tx_scheduler
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 9
) (
  input  logic                  CLK,
  input  logic                  INITIALIZE,
  input  logic [1:0]            req_valid,
  input  logic [1:0]            req_word,
  input  logic [31:0]           req_data0,
  input  logic [31:0]           req_data1,
  output logic [1:0]            req_ready,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  idle
);

`ifdef HEX_PRINT_EN
  localparam int unsigned NeedWord = HEX_WORD_BYTES;
  localparam int unsigned Step     = 4;

  function automatic logic [7:0] emit(input logic [31:0] x);
    return hex_ascii(x[31:28]);
  endfunction
`else
  localparam int unsigned NeedWord = WORD_BYTES;
  localparam int unsigned Step     = 8;

  function automatic logic [7:0] emit(input logic [31:0] x);
    return x[31:24];
  endfunction
`endif

  localparam int unsigned        Cap       = 2**DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] CapL     = (DEPTH_LOG2+1)'(Cap);
  localparam logic [DEPTH_LOG2:0] NeedWordL = (DEPTH_LOG2+1)'(NeedWord);
  localparam logic [DEPTH_LOG2:0] NeedByteL = (DEPTH_LOG2+1)'(1);
  localparam logic [2:0]          LeftInit  = 3'(NeedWord - 1);

  tx_sched_state_t     state_q;
  logic [31:0]         shreg_q;
  logic [2:0]          left_q;
  logic                prio_q;

  logic [DEPTH_LOG2:0] free;
  logic [1:0]          elig;
  logic [1:0]          grant;
  logic                sel_word;
  logic [31:0]         sel_data;
  logic                wr_en;
  logic [7:0]          wr_data;

  assign free = CapL - level;

  always_comb begin
    elig  = '0;
    grant = '0;
    for (int p = 0; p < 2; p++) begin
      elig[p] = req_valid[p] && (free >= (req_word[p] ? NeedWordL : NeedByteL));
    end
    if (state_q == S_IDLE && !INITIALIZE) begin
      if (elig == 2'b11) begin
        grant = prio_q ? 2'b10 : 2'b01;
      end else begin
        grant = elig;
      end
    end
  end

  assign sel_word  = grant[1] ? req_word[1] : req_word[0];
  assign sel_data  = grant[1] ? req_data1 : req_data0;
  assign req_ready = grant;

  // The head byte of a word is written in the accept cycle; the rest come from the shift register.
  always_comb begin
    wr_en   = 1'b0;
    wr_data = 8'h00;
    if (state_q == S_WRITE) begin
      wr_en   = 1'b1;
      wr_data = emit(shreg_q);
    end else if (grant != 2'b00) begin
      wr_en   = 1'b1;
      wr_data = sel_word ? emit(sel_data) : sel_data[7:0];
    end
  end

  always_ff @(posedge CLK or posedge INITIALIZE) begin
    if (INITIALIZE) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      left_q  <= '0;
      prio_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (grant != 2'b00) begin
            // Priority passes to the port that was not just served.
            prio_q <= grant[0];
            if (sel_word) begin
              shreg_q <= sel_data << Step;
              left_q  <= LeftInit;
              state_q <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          shreg_q <= shreg_q << Step;
          left_q  <= left_q - 3'd1;
          if (left_q == 3'd1) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  tx_byte_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .CLK        (CLK),
    .INITIALIZE (INITIALIZE),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .rd_en      (tx_ready),
    .rd_data    (tx_data),
    .level      (level)
  );

  assign tx_valid = (level != '0);
  assign idle     = (state_q == S_IDLE) && (level == '0);

  no_overflow_a : assert property (@(posedge CLK) disable iff (INITIALIZE)
    !(wr_en && level == CapL && !tx_ready));
  no_grant_in_write_a : assert property (@(posedge CLK) disable iff (INITIALIZE)
    !(state_q == S_WRITE && req_ready != 2'b00));

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: hand-built vector tables, corner sequences and a
// randomized run against a queue-based reference model.
module tb_uart_tx_scheduler;

  localparam int CAP = 512;
`ifdef HEX_PRINT_EN
  localparam int WORD_LEN = 8;
`else
  localparam int WORD_LEN = 4;
`endif

  logic        CLK = 1'b0;
  logic        INITIALIZE = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_word = '0;
  logic [31:0] req_data0 = '0;
  logic [31:0] req_data1 = '0;
  logic [1:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [9:0]  level;
  logic        idle;

  uart_tx_scheduler #(.DEPTH_LOG2(9)) dut (
    .CLK        (CLK),
    .INITIALIZE (INITIALIZE),
    .req_valid  (req_valid),
    .req_word   (req_word),
    .req_data0  (req_data0),
    .req_data1  (req_data1),
    .req_ready  (req_ready),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .level      (level),
    .idle       (idle)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model: bytes sitting in the queue, bytes of a word still to be written, and
  // which port wins a tie.
  int  mq[$];
  int  mp[$];
  bit  mprio;

  // Values seen in the most recent cycle, for hand-written expectations.
  logic [1:0] s_ready;
  int         s_level;
  logic       s_txv;
  logic [7:0] s_txd;
  logic       s_idle;
  logic [1:0] g;

  typedef struct {
    logic [1:0]  v;
    logic [1:0]  w;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        tr;
    logic [1:0]  rdy;
    int          lvl;
    logic        txv;
    logic [7:0]  txd;
    logic        idl;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int hex_char(input int nib);
    return (nib < 10) ? (48 + nib) : (97 + nib - 10);
  endfunction

  task automatic model_clear();
    mq.delete();
    mp.delete();
    mprio = 1'b0;
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, advance the model.
  task automatic cyc(input logic [1:0] v, input logic [1:0] w, input logic [31:0] d0,
                     input logic [31:0] d1, input logic tr, output logic [1:0] gnt);
    logic [1:0]  eg;
    logic [1:0]  er;
    logic [31:0] d;
    int          free;
    int          p;
    req_valid = v;
    req_word  = w;
    req_data0 = d0;
    req_data1 = d1;
    tx_ready  = tr;
    #3;
    free = CAP - mq.size();
    er   = 2'b00;
    if (mp.size() == 0) begin
      for (int i = 0; i < 2; i++) begin
        eg[i] = v[i] && (free >= (w[i] ? WORD_LEN : 1));
      end
      if (eg == 2'b11) er = mprio ? 2'b10 : 2'b01;
      else             er = eg;
    end
    s_ready = req_ready;
    s_level = int'(level);
    s_txv   = tx_valid;
    s_txd   = tx_data;
    s_idle  = idle;
    check("req_ready", req_ready, er);
    check("level", level, mq.size());
    check("tx_valid", tx_valid, mq.size() != 0);
    if (mq.size() != 0) check("tx_data", tx_data, mq[0]);
    check("idle", idle, (mp.size() == 0) && (mq.size() == 0));
    if (mq.size() != 0 && tr) void'(mq.pop_front());
    if (er != 2'b00) begin
      p = er[1] ? 1 : 0;
      d = p ? d1 : d0;
      mprio = (p == 0);
      if (w[p]) begin
        for (int i = 0; i < WORD_LEN; i++) begin
          if (WORD_LEN == 8) mp.push_back(hex_char(int'((d >> (28 - 4 * i)) & 32'hF)));
          else               mp.push_back(int'((d >> (24 - 8 * i)) & 32'hFF));
        end
      end else begin
        mp.push_back(int'(d & 32'hFF));
      end
    end
    if (mp.size() != 0) mq.push_back(mp.pop_front());
    gnt = er;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    req_valid  = '0;
    req_word   = '0;
    tx_ready   = 1'b0;
    INITIALIZE = 1'b1;
    #3;
    check("rst_req_ready", req_ready, 2'b00);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_level", level, 0);
    check("rst_idle", idle, 1'b1);
    @(posedge CLK);
    #1;
    INITIALIZE = 1'b0;
    model_clear();
  endtask

  task automatic run_tbl(input string name);
    logic [1:0] gg;
    do_reset();
    foreach (tbl[i]) begin
      cyc(tbl[i].v, tbl[i].w, tbl[i].d0, tbl[i].d1, tbl[i].tr, gg);
      check({name, "_ready"}, s_ready, tbl[i].rdy);
      check({name, "_level"}, s_level, tbl[i].lvl);
      check({name, "_txv"}, s_txv, tbl[i].txv);
      if (tbl[i].txv) check({name, "_txd"}, s_txd, tbl[i].txd);
      check({name, "_idle"}, s_idle, tbl[i].idl);
    end
    tbl.delete();
  endtask

  logic [1:0]  hv;
  logic [1:0]  hw;
  logic [31:0] hd [2];

  task automatic random_phase(input int n, input int tr_pct);
    logic [1:0] gg;
    for (int c = 0; c < n; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!hv[p] && $urandom_range(0, 99) < 40) begin
          hv[p] = 1'b1;
          hw[p] = ($urandom_range(0, 3) == 0);
          hd[p] = $urandom;
        end
      end
      cyc(hv, hw, hd[0], hd[1], $urandom_range(0, 99) < tr_pct, gg);
      hv = hv & ~gg;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge CLK);
    #1;
    model_clear();

`ifndef HEX_PRINT_EN
    // Word 0x12345678 goes out MSB first.
    tbl.push_back('{2'b01, 2'b01, 32'h12345678, 32'h0, 1'b1, 2'b01, 0, 1'b0, 8'h00, 1'b1});
    tbl.push_back('{2'b00, 2'b00, 32'h0, 32'h0, 1'b1, 2'b00, 1, 1'b1, 8'h12, 1'b0});
    tbl.push_back('{2'b00, 2'b00, 32'h0, 32'h0, 1'b1, 2'b00, 1, 1'b1, 8'h34, 1'b0});
    tbl.push_back('{2'b00, 2'b00, 32'h0, 32'h0, 1'b1, 2'b00, 1, 1'b1, 8'h56, 1'b0});
    tbl.push_back('{2'b00, 2'b00, 32'h0, 32'h0, 1'b1, 2'b00, 1, 1'b1, 8'h78, 1'b0});
    tbl.push_back('{2'b00, 2'b00, 32'h0, 32'h0, 1'b1, 2'b00, 0, 1'b0, 8'h00, 1'b1});
    run_tbl("word");
`else
    tbl.push_back('{2'b01, 2'b01, 32'h00ABCDEF, 32'h0, 1'b1, 2'b01, 0, 1'b0, 8'h00, 1'b1});
    tbl.push_back('{2'b00, 2'b00, 32'h0, 32'h0, 1'b1, 2'b00, 1, 1'b1, 8'h30, 1'b0});
    tbl.push_back('{2'b00, 2'b00, 32'h0, 32'h0, 1'b1, 2'b00, 1, 1'b1, 8'h30, 1'b0});
    tbl.push_back('{2'b00, 2'b00, 32'h0, 32'h0, 1'b1, 2'b00, 1, 1'b1, 8'h61, 1'b0});
    tbl.push_back('{2'b00, 2'b00, 32'h0, 32'h0, 1'b1, 2'b00, 1, 1'b1, 8'h62, 1'b0});
    tbl.push_back('{2'b00, 2'b00, 32'h0, 32'h0, 1'b1, 2'b00, 1, 1'b1, 8'h63, 1'b0});
    tbl.push_back('{2'b00, 2'b00, 32'h0, 32'h0, 1'b1, 2'b00, 1, 1'b1, 8'h64, 1'b0});
    tbl.push_back('{2'b00, 2'b00, 32'h0, 32'h0, 1'b1, 2'b00, 1, 1'b1, 8'h65, 1'b0});
    tbl.push_back('{2'b00, 2'b00, 32'h0, 32'h0, 1'b1, 2'b00, 1, 1'b1, 8'h66, 1'b0});
    tbl.push_back('{2'b00, 2'b00, 32'h0, 32'h0, 1'b1, 2'b00, 0, 1'b0, 8'h00, 1'b1});
    run_tbl("hex");
`endif

    // Two byte requesters alternate.
    for (int i = 0; i < 4; i++) begin
      tbl.push_back('{2'b11, 2'b00, 32'h41, 32'h42, 1'b1, (i % 2 == 0) ? 2'b01 : 2'b10,
                      (i == 0) ? 0 : 1, i != 0, (i % 2 == 1) ? 8'h41 : 8'h42, i == 0});
    end
    tbl.push_back('{2'b00, 2'b00, 32'h0, 32'h0, 1'b1, 2'b00, 1, 1'b1, 8'h42, 1'b0});
    tbl.push_back('{2'b00, 2'b00, 32'h0, 32'h0, 1'b1, 2'b00, 0, 1'b0, 8'h00, 1'b1});
    run_tbl("rr");

`ifndef HEX_PRINT_EN
    // Space reservation near full, and the full-queue boundary.
    do_reset();
    for (int i = 0; i < 510; i++) cyc(2'b01, 2'b00, 32'(i), 32'h0, 1'b0, g);
    cyc(2'b11, 2'b10, 32'h55, 32'hCAFEF00D, 1'b0, g);
    check("near_full_level", s_level, 510);
    check("near_full_grant", s_ready, 2'b01);
    for (int i = 0; i < 3; i++) begin
      cyc(2'b10, 2'b10, 32'h0, 32'hCAFEF00D, 1'b1, g);
      check("starved_word", s_ready, 2'b00);
      check("starved_level", s_level, 511 - i);
    end
    cyc(2'b10, 2'b10, 32'h0, 32'hCAFEF00D, 1'b0, g);
    check("word_fits", s_ready, 2'b10);
    check("word_fits_level", s_level, 508);
    for (int i = 0; i < 3; i++) begin
      cyc(2'b01, 2'b00, 32'h77, 32'h0, 1'b0, g);
      check("no_accept_in_write", s_ready, 2'b00);
    end
    cyc(2'b01, 2'b00, 32'h77, 32'h0, 1'b1, g);
    check("full_level", s_level, 512);
    check("full_no_accept", s_ready, 2'b00);
    cyc(2'b01, 2'b00, 32'h77, 32'h0, 1'b0, g);
    check("after_full_accept", s_ready, 2'b01);
    for (int i = 0; i < 520; i++) cyc(2'b00, 2'b00, 32'h0, 32'h0, 1'b1, g);
    cyc(2'b00, 2'b00, 32'h0, 32'h0, 1'b1, g);
    check("drained_level", s_level, 0);
`endif

    // Pointer wrap with interleaved fill and drain.
    do_reset();
    for (int i = 0; i < 400; i++) cyc(2'b01, 2'b00, $urandom, 32'h0, 1'b0, g);
    for (int i = 0; i < 250; i++) cyc(2'b00, 2'b00, 32'h0, 32'h0, 1'b1, g);
    for (int i = 0; i < 350; i++) cyc(2'b01, 2'b00, $urandom, 32'h0, 1'b0, g);
    check("wrap_level", level, 500);
    for (int i = 0; i < 520; i++) cyc(2'b00, 2'b00, 32'h0, 32'h0, 1'b1, g);
    check("wrap_drained", level, 0);
    check("wrap_idle", idle, 1'b1);

    // Reset during the second write cycle of a word.
    do_reset();
    cyc(2'b01, 2'b01, 32'hDEADBEEF, 32'h0, 1'b1, g);
    cyc(2'b00, 2'b00, 32'h0, 32'h0, 1'b1, g);
    INITIALIZE = 1'b1;
    #2;
    check("midrst_tx_valid", tx_valid, 1'b0);
    check("midrst_level", level, 0);
    check("midrst_idle", idle, 1'b1);
    @(posedge CLK);
    #1;
    INITIALIZE = 1'b0;
    model_clear();
    cyc(2'b10, 2'b00, 32'h0, 32'h5A, 1'b0, g);
    check("postrst_grant", s_ready, 2'b10);
    cyc(2'b00, 2'b00, 32'h0, 32'h0, 1'b1, g);
    check("postrst_txv", s_txv, 1'b1);
    check("postrst_txd", s_txd, 8'h5A);
    cyc(2'b00, 2'b00, 32'h0, 32'h0, 1'b1, g);
    check("postrst_empty", s_level, 0);

    // Randomized traffic against the model: a filling phase, a draining phase, then empty out.
    do_reset();
    hv = '0;
    hw = '0;
    random_phase(2000, 20);
    random_phase(2000, 80);
    for (int i = 0; i < 600; i++) begin
      cyc(hv, hw, hd[0], hd[1], 1'b1, g);
      hv = hv & ~g;
    end
    check("random_drained", level, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
